// File: rtl/ram_bus_be.sv
// Single-port synchronous data RAM with byte-write strobes and a valid/ready request/response pipeline.
// Read latency is 1 or 2 cycles. Out-of-range accesses are flagged with rsp_err and never alias.
module ram_bus_be #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned LATENCY     = 1,
    parameter bit          WRITE_FIRST = 1'b0,
    parameter string       archivo     = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              advance;
    logic              accept;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] rd_next;

    logic              s1_valid;
    logic              s1_err;
    logic [DATA_W-1:0] s1_data;

    // The whole pipeline moves only when the output slot is free or being consumed.
    assign advance   = !rst && (rsp_ready || !rsp_valid);
    assign req_ready = advance;
    assign accept    = req_valid && advance;

    // Compare on the full address so addresses >= DEPTH never wrap into the array.
    assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
    assign idx       = IDX_W'(req_addr);
    assign old_word  = mem[idx];

    always_comb begin
        merged = old_word;
        for (int i = 0; i < NB; i++) begin
            if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    always_comb begin
        rd_next = '0;
        if (in_range) rd_next = (req_we && WRITE_FIRST) ? merged : old_word;
    end

    // Byte-lane writes; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept && req_we && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_data  <= '0;
        end else if (advance) begin
            s1_valid <= accept;
            s1_err   <= accept && !in_range;
            s1_data  <= accept ? rd_next : '0;
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            assign rsp_valid = s1_valid;
            assign rsp_err   = s1_err;
            assign rsp_rdata = s1_data;
        end else begin : g_lat2
            logic              s2_valid;
            logic              s2_err;
            logic [DATA_W-1:0] s2_data;

            // Extra output register; frozen together with stage 1 on a stall.
            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_err   <= 1'b0;
                    s2_data  <= '0;
                end else if (advance) begin
                    s2_valid <= s1_valid;
                    s2_err   <= s1_err;
                    s2_data  <= s1_data;
                end
            end

            assign rsp_valid = s2_valid;
            assign rsp_err   = s2_err;
            assign rsp_rdata = s2_data;
        end
    endgenerate

endmodule

// File: tb/tb_ram_bus_be.sv
// Bench for ram_bus_be: two instances (LAT=1/DEPTH=512/read-first, LAT=2/DEPTH=500/write-first)
// driven by directed and random traffic, scored against a per-instance timed response queue.
module tb_ram_bus_be;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic                req_we;
    logic [AW-1:0]       req_addr;
    logic [DW-1:0]       req_wdata;
    logic [3:0]          req_be;
    logic [1:0]          rsp_valid;
    logic                rsp_ready;
    logic [1:0][DW-1:0]  rsp_rdata;
    logic [1:0]          rsp_err;

    always #5 clk = ~clk;

    ram_bus_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(512), .LATENCY(1), .WRITE_FIRST(1'b0), .archivo("")) u_dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid[0]),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    ram_bus_be #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(500), .LATENCY(2), .WRITE_FIRST(1'b1), .archivo("")) u_dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid[1]),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        known;
        int          due;
    } rsp_t;

    rsp_t        q [2][$];
    logic [31:0] m [2][1024];
    bit          known [2][1024];
    int          cyc;
    int          n_chk;
    int          n_fail;
    logic [31:0] got [2];
    logic [31:0] got_err [2];
    bit          rnd;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int depth(input int d);
        return (d == 0) ? 512 : 500;
    endfunction

    function automatic bit wf(input int d);
        return d == 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply the current request to the reference memory and return the response it must produce.
    function automatic rsp_t access(input int d);
        rsp_t        r;
        logic [31:0] nw;
        int          a;
        a     = int'(req_addr);
        r.due = cyc + lat(d);
        if (a >= depth(d)) begin
            r.data  = 32'h0;
            r.err   = 1'b1;
            r.known = 1'b1;
        end else begin
            r.err = 1'b0;
            nw    = m[d][a];
            if (req_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (req_be[i]) nw[8*i +: 8] = req_wdata[8*i +: 8];
                end
                r.data  = wf(d) ? nw : m[d][a];
                r.known = wf(d) ? (known[d][a] || req_be == 4'hF) : known[d][a];
                m[d][a] = nw;
                known[d][a] = known[d][a] || (req_be == 4'hF);
            end else begin
                r.data  = nw;
                r.known = known[d][a];
            end
        end
        return r;
    endfunction

    // One clock: check req_ready before the edge, update the model at the edge, check outputs after.
    task automatic step();
        logic [1:0] acc;
        bit         vv [2];
        bit         advv [2];
        rsp_t       e;
        if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
        #1;
        for (int d = 0; d < 2; d++) begin
            vv[d]   = (q[d].size() > 0) && (q[d][0].due == cyc);
            advv[d] = !rst && (rsp_ready || !vv[d]);
            chk($sformatf("d%0d_req_ready", d), 32'(req_ready[d]), 32'(advv[d]));
            acc[d] = req_valid[d] && advv[d];
            if (vv[d] && rsp_ready) begin
                got[d]     = rsp_rdata[d];
                got_err[d] = 32'(rsp_err[d]);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                q[d].delete();
            end else if (!advv[d]) begin
                for (int i = 0; i < q[d].size(); i++) begin
                    e = q[d][i];
                    e.due = e.due + 1;
                    q[d][i] = e;
                end
            end else begin
                if (vv[d]) void'(q[d].pop_front());
                if (acc[d]) q[d].push_back(access(d));
            end
        end
        cyc++;
        #1;
        for (int d = 0; d < 2; d++) begin
            vv[d] = (q[d].size() > 0) && (q[d][0].due == cyc);
            chk($sformatf("d%0d_rsp_valid", d), 32'(rsp_valid[d]), 32'(vv[d]));
            if (vv[d]) begin
                chk($sformatf("d%0d_rsp_err", d), 32'(rsp_err[d]), 32'(q[d][0].err));
                if (q[d][0].known) chk($sformatf("d%0d_rsp_rdata", d), rsp_rdata[d], q[d][0].data);
            end
        end
        req_valid = req_valid & ~acc;
    endtask

    task automatic issue(input logic we, input logic [AW-1:0] a, input logic [31:0] wd, input logic [3:0] be);
        int n;
        n = 0;
        req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_valid = 2'b11;
        while (req_valid != 2'b00 && n < 100) begin
            step();
            n++;
        end
        req_valid = 2'b00;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rnd = 0;
        rsp_ready = 1'b1;
        while ((q[0].size() + q[1].size()) != 0 && n < 50) begin
            step();
            n++;
        end
        step();
    endtask

    initial begin
        logic [31:0] w;
        logic [AW-1:0] a;
        int r;
        n_chk = 0; n_fail = 0; cyc = 0; rnd = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 1024; i++) begin
                m[d][i] = 32'h0;
                known[d][i] = 1'b0;
            end
            got[d] = 32'h0; got_err[d] = 32'h0;
        end
        rst = 1'b1; req_valid = 2'b00; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        rsp_ready = 1'b1;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_reset_rdata", d), rsp_rdata[d], 32'h0);
            chk($sformatf("d%0d_reset_err", d), 32'(rsp_err[d]), 32'h0);
        end
        rst = 1'b0;

        // Initialise a working set, including the region around the DEPTH=500 boundary.
        for (int i = 0; i < 16; i++) issue(1'b1, AW'(i), $urandom, 4'hF);
        for (int i = 496; i < 512; i++) issue(1'b1, AW'(i), $urandom, 4'hF);
        issue(1'b1, AW'(88), 32'h8888_0088, 4'hF);
        drain();

        // Full write then back-to-back read.
        issue(1'b1, AW'(5), 32'hDEAD_BEEF, 4'hF);
        issue(1'b0, AW'(5), 32'h0, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_t1_read", d), got[d], 32'hDEAD_BEEF);
            chk($sformatf("d%0d_t1_err", d), got_err[d], 32'h0);
        end

        // Single-lane write, then a be=0 no-op write.
        issue(1'b1, AW'(5), 32'h0000_AA00, 4'b0010);
        issue(1'b0, AW'(5), 32'h0, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t2_partial", d), got[d], 32'hDEAD_AAEF);
        issue(1'b1, AW'(5), 32'hFFFF_FFFF, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t2_be0_rsp", d), got[d], 32'hDEAD_AAEF);
        issue(1'b0, AW'(5), 32'h0, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t2_be0_read", d), got[d], 32'hDEAD_AAEF);

        // Back-to-back reads then a 3-cycle response stall with a request waiting.
        for (int i = 0; i < 4; i++) issue(1'b0, AW'(i), 32'h0, 4'h0);
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = AW'(4); req_valid = 2'b11;
        for (int i = 0; i < 3; i++) step();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t3_stall_ready", d), 32'(req_ready[d]), 32'h0);
        drain();
        req_valid = 2'b00;
        drain();

        // Out-of-range accesses must not write or alias (600 mod 512 = 88).
        issue(1'b1, AW'(600), 32'hCAFE_F00D, 4'hF);
        drain();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_t4_oor_err", d), got_err[d], 32'h1);
            chk($sformatf("d%0d_t4_oor_rdata", d), got[d], 32'h0);
        end
        issue(1'b0, AW'(88), 32'h0, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t4_no_alias", d), got[d], 32'h8888_0088);
        issue(1'b0, AW'(499), 32'h0, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t4_last_err", d), got_err[d], 32'h0);
        issue(1'b0, AW'(500), 32'h0, 4'h0);
        drain();
        chk("d0_t4_500_err", got_err[0], 32'h0);
        chk("d1_t4_500_err", got_err[1], 32'h1);

        // Write response data: read-first vs write-first.
        issue(1'b1, AW'(7), 32'h1111_1111, 4'hF);
        issue(1'b1, AW'(7), 32'h2222_2222, 4'hF);
        drain();
        chk("d0_t5_read_first", got[0], 32'h1111_1111);
        chk("d1_t5_write_first", got[1], 32'h2222_2222);

        // Random traffic with random back-pressure and idle bubbles.
        rnd = 1;
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 15);
            if (r < 12)      a = AW'($urandom_range(0, 15));
            else if (r < 14) a = AW'($urandom_range(490, 520));
            else             a = AW'($urandom_range(0, 1023));
            w = $urandom;
            issue(1'($urandom_range(0, 1)), a, w, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) step();
        end
        drain();

        // Reset with responses in flight.
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = AW'(3); req_valid = 2'b11;
        step();
        req_addr = AW'(4); req_valid = 2'b11;
        step();
        req_valid = 2'b00;
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t6_inflight", d), 32'(rsp_valid[d]), 32'h1);
        rst = 1'b1;
        step();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_t6_rst_valid", d), 32'(rsp_valid[d]), 32'h0);
            chk($sformatf("d%0d_t6_rst_rdata", d), rsp_rdata[d], 32'h0);
            chk($sformatf("d%0d_t6_rst_err", d), 32'(rsp_err[d]), 32'h0);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) step();
        issue(1'b0, AW'(3), 32'h0, 4'h0);
        drain();
        for (int d = 0; d < 2; d++) chk($sformatf("d%0d_t6_retained", d), got[d], m[d][3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
